// File: rtl/gcd_job_dispatcher.sv
// gcd_job_dispatcher: buffers (a,b) operand pairs in a small FIFO, issues one
// job at a time to an external GCD core with a single-cycle Begin pulse,
// captures the gcd on the rising edge of Complete and presents {a,b,gcd} on a
// valid/ready result port. Results leave in push order.
// Optional feature: define GCD_DISP_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYC cycles. A timed-out job is reported with out_gcd=0, out_err=1.
module gcd_job_dispatcher #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_begin,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_complete,
    input  logic [WIDTH-1:0] core_gcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] mem_a_r [DEPTH];
    logic [WIDTH-1:0] mem_b_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             complete_q_r;
    logic             push_s;
    logic             pop_s;
    logic             rise_s;
    logic             timeout_s;

    // Pointer wrap relies on DEPTH being a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_bad_params
        $error("gcd_job_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
    end

    // No bypass: a full FIFO refuses even when a pop happens in the same cycle.
    assign in_ready = (count_r != FULL_COUNT);
    assign push_s   = in_valid && in_ready;
    assign pop_s    = (state_r == IDLE) && (count_r != {CW{1'b0}});
    assign rise_s   = core_complete && !complete_q_r;
    assign busy     = (state_r != IDLE) || (count_r != {CW{1'b0}});

    // FIFO storage: data only, no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= in_a;
            mem_b_r[wr_ptr_r] <= in_b;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Delayed copy of Complete for rising-edge detection in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            complete_q_r <= 1'b0;
        end else begin
            complete_q_r <= core_complete;
        end
    end

`ifdef GCD_DISP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] wait_cnt_r;

    assign timeout_s = (state_r == WAIT) && !rise_s && (wait_cnt_r == LAST_WAIT);

    // WAIT cycle counter, cleared during ISSUE so it starts at zero in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end
    end

    // Error flag: set on timeout, cleared when that result is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (timeout_s) begin
            out_err <= 1'b1;
        end else if ((state_r == HOLD) && out_ready) begin
            out_err <= 1'b0;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign out_err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) next_state_s = ISSUE;
                else       next_state_s = IDLE;
            end
            ISSUE: next_state_s = WAIT;
            WAIT: begin
                if (rise_s || timeout_s) next_state_s = HOLD;
                else                     next_state_s = WAIT;
            end
            HOLD: begin
                if (out_ready) next_state_s = IDLE;
                else           next_state_s = HOLD;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Registered core and result outputs, updated only at the state's defined moment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_begin <= 1'b0;
            core_a     <= {WIDTH{1'b0}};
            core_b     <= {WIDTH{1'b0}};
            out_valid  <= 1'b0;
            out_a      <= {WIDTH{1'b0}};
            out_b      <= {WIDTH{1'b0}};
            out_gcd    <= {WIDTH{1'b0}};
        end else begin
            core_begin <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        core_a     <= mem_a_r[rd_ptr_r];
                        core_b     <= mem_b_r[rd_ptr_r];
                        out_a      <= mem_a_r[rd_ptr_r];
                        out_b      <= mem_b_r[rd_ptr_r];
                        core_begin <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rise_s) begin
                        out_gcd   <= core_gcd;
                        out_valid <= 1'b1;
                    end else if (timeout_s) begin
                        out_gcd   <= {WIDTH{1'b0}};
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= out_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Self-checking bench for gcd_job_dispatcher with a behavioural GCD core model.
// Expected results come from a Euclid reference and the order of accepted pushes.
module tb_gcd_job_dispatcher;
    localparam int W = 16;

    logic         clk, rst_n, in_valid, in_ready, core_begin, core_complete;
    logic         out_valid, out_ready, out_err, busy;
    logic [W-1:0] in_a, in_b, core_a, core_b, core_gcd, out_a, out_b, out_gcd;

    int   tests = 0;
    int   fails = 0;
    int   core_lat, core_hold;
    logic core_stall, core_flush;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic         err;
    } res_t;
    res_t got_q[$];

    gcd_job_dispatcher #(.WIDTH(W), .DEPTH(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .core_begin(core_begin), .core_a(core_a),
        .core_b(core_b), .core_complete(core_complete), .core_gcd(core_gcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_gcd(out_gcd), .out_err(out_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // GCD core model: latches operands on Begin, answers after core_lat cycles,
    // holds Complete for core_hold cycles; core_stall freezes the countdown.
    initial begin : core_model
        int lat_left, hold_left;
        logic [W-1:0] res;
        lat_left = 0; hold_left = 0; res = 16'd0;
        core_complete = 1'b0; core_gcd = 16'd0;
        forever begin
            @(posedge clk); #1;
            if (core_flush) begin
                lat_left = 0; hold_left = 0; core_complete = 1'b0;
            end else begin
                if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) begin
                        core_complete = 1'b0;
                        core_gcd = 16'($urandom);
                    end
                end
                if (lat_left > 0 && !core_stall) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        core_gcd = res; core_complete = 1'b1; hold_left = core_hold;
                    end
                end
                if (core_begin) begin
                    res = ref_gcd(core_a, core_b);
                    lat_left = core_lat;
                end
            end
        end
    end

    // Result monitor: records every result handshake in order.
    initial begin : result_monitor
        res_t r;
        forever begin
            @(posedge clk); #3;
            if (out_valid && out_ready) begin
                r.a = out_a; r.b = out_b; r.g = out_gcd; r.err = out_err;
                got_q.push_back(r);
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic rand_pair(output logic [W-1:0] a, output logic [W-1:0] b);
        int g, x, y;
        g = $urandom_range(1, 250); x = $urandom_range(0, 250); y = $urandom_range(0, 250);
        a = 16'(g * x);
        b = 16'(g * y);
    endtask

    task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b, output logic ok);
        in_valid = 1'b1; in_a = a; in_b = b; ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, output logic ok);
        for (int c = 0; c < 600 && got_q.size() < n; c++) step();
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b1;
        core_stall = 1'b0; core_flush = 1'b0; core_lat = 3; core_hold = 1;
        repeat (3) step();
        tests++;
        if ({core_begin, core_a, core_b, out_valid, out_a, out_b, out_gcd, out_err, busy} !== 87'd0) begin
            fails++; $display("FAIL reset_outputs: got %h required 0",
                {core_begin, core_a, core_b, out_valid, out_a, out_b, out_gcd, out_err, busy});
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic seen, ok;
        int base;
        base = got_q.size(); core_lat = 3; core_hold = 1; out_ready = 1'b1;
        in_a = 16'd12; in_b = 16'd18; in_valid = 1'b1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b required 1", in_ready); end
        step(); in_valid = 1'b0;
        tests++; if (core_begin !== 1'b0) begin fails++; $display("FAIL basic_begin_early: got %b required 0", core_begin); end
        step();
        tests++; if (core_begin !== 1'b1) begin fails++; $display("FAIL basic_begin_n2: got %b required 1", core_begin); end
        tests++; if (core_a !== 16'd12 || core_b !== 16'd18) begin fails++; $display("FAIL basic_core_ops: got %0d,%0d required 12,18", core_a, core_b); end
        step();
        tests++; if (core_begin !== 1'b0) begin fails++; $display("FAIL basic_begin_width: got %b required 0", core_begin); end
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (core_complete) seen = 1'b1;
            else step();
        end
        tests++; if (!seen || out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early: seen=%b out_valid=%b required 1 0", seen, out_valid); end
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_latency: got %b required 1", out_valid); end
        tests++;
        if (out_gcd !== 16'd6 || out_a !== 16'd12 || out_b !== 16'd18 || out_err !== 1'b0) begin
            fails++; $display("FAIL basic_result: got a=%0d b=%0d g=%0d e=%b required 12 18 6 0", out_a, out_b, out_gcd, out_err);
        end
        wait_got(base + 1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_handshake: got %0d results required %0d", got_q.size(), base + 1); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ea[6], eb[6];
        logic ok, sticky;
        int base;
        res_t r;
        base = got_q.size(); core_lat = 2; core_hold = 1; core_stall = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) rand_pair(ea[i], eb[i]);
        for (int i = 0; i < 5; i++) begin
            push_one(ea[i], eb[i], ok);
            tests++; if (!ok) begin fails++; $display("FAIL b2b_push%0d: not accepted", i); end
        end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: in_ready=%b required 0", in_ready); end
        in_valid = 1'b1; in_a = ea[5]; in_b = eb[5]; sticky = 1'b0;
        repeat (5) begin
            sticky = sticky | in_ready;
            step();
        end
        tests++; if (sticky !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_stay_full: ready_seen=%b busy=%b required 0 1", sticky, busy); end
        core_stall = 1'b0; ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL b2b_push5: not accepted"); end
        wait_got(base + 6, ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_count: got %0d results required %0d", got_q.size(), base + 6); end
        for (int i = 0; i < 6; i++) begin
            r = got_q[base + i];
            tests++;
            if (r.a !== ea[i] || r.b !== eb[i] || r.g !== ref_gcd(ea[i], eb[i]) || r.err !== 1'b0) begin
                fails++; $display("FAIL b2b_result%0d: got %0d,%0d,%0d,%b required %0d,%0d,%0d,0",
                    i, r.a, r.b, r.g, r.err, ea[i], eb[i], ref_gcd(ea[i], eb[i]));
            end
        end
    endtask

    task automatic test_hold_stall();
        logic [W-1:0] ea[2], eb[2], sa, sb, sg;
        logic ok;
        int base;
        res_t r;
        base = got_q.size(); core_lat = 2; core_hold = 1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_pair(ea[i], eb[i]);
            push_one(ea[i], eb[i], ok);
        end
        for (int c = 0; c < 100 && !out_valid; c++) step();
        sa = out_a; sb = out_b; sg = out_gcd;
        tests++; if (sa !== ea[0] || sg !== ref_gcd(ea[0], eb[0])) begin fails++; $display("FAIL hold_first: got %0d,%0d required %0d,%0d", sa, sg, ea[0], ref_gcd(ea[0], eb[0])); end
        for (int c = 0; c < 10; c++) begin
            step();
            tests++;
            if (out_valid !== 1'b1 || out_a !== sa || out_b !== sb || out_gcd !== sg || core_begin !== 1'b0) begin
                fails++; $display("FAIL hold_stable%0d: valid=%b a=%0d b=%0d g=%0d begin=%b", c, out_valid, out_a, out_b, out_gcd, core_begin);
            end
        end
        out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b0 || core_begin !== 1'b0) begin fails++; $display("FAIL hold_after_hs: valid=%b begin=%b required 0 0", out_valid, core_begin); end
        step();
        tests++; if (core_begin !== 1'b1) begin fails++; $display("FAIL hold_next_begin: got %b required 1", core_begin); end
        wait_got(base + 2, ok);
        for (int i = 0; i < 2; i++) begin
            r = got_q[base + i];
            tests++;
            if (r.a !== ea[i] || r.b !== eb[i] || r.g !== ref_gcd(ea[i], eb[i])) begin
                fails++; $display("FAIL hold_result%0d: got %0d,%0d,%0d required %0d,%0d,%0d", i, r.a, r.b, r.g, ea[i], eb[i], ref_gcd(ea[i], eb[i]));
            end
        end
    endtask

    task automatic test_passthrough();
        logic [W-1:0] ea[3], eb[3], eg[3];
        logic ok;
        int base;
        res_t r;
        ea[0] = 16'd0; eb[0] = 16'd7; eg[0] = 16'd7;
        ea[1] = 16'd9; eb[1] = 16'd0; eg[1] = 16'd9;
        ea[2] = 16'd0; eb[2] = 16'd0; eg[2] = 16'd0;
        base = got_q.size(); core_lat = 2; core_hold = 3; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_one(ea[i], eb[i], ok);
        wait_got(base + 3, ok);
        repeat (15) step();
        tests++; if (got_q.size() != base + 3) begin fails++; $display("FAIL pass_capture_count: got %0d required %0d", got_q.size(), base + 3); end
        for (int i = 0; i < 3; i++) begin
            r = got_q[base + i];
            tests++;
            if (r.a !== ea[i] || r.b !== eb[i] || r.g !== eg[i]) begin
                fails++; $display("FAIL pass_result%0d: got %0d,%0d,%0d required %0d,%0d,%0d", i, r.a, r.b, r.g, ea[i], eb[i], eg[i]);
            end
        end
        core_hold = 1;
    endtask

    task automatic test_timeout();
        logic [W-1:0] a, b;
        logic ok;
        int base;
        res_t r;
        base = got_q.size(); core_lat = 2; core_hold = 1; out_ready = 1'b1; core_stall = 1'b1;
        rand_pair(a, b);
        push_one(a, b, ok);
`ifdef GCD_DISP_TIMEOUT_EN
        begin
            logic seen;
            int cnt;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (core_begin) seen = 1'b1;
                else step();
            end
            cnt = 0;
            while (!out_valid && cnt < 100) begin step(); cnt++; end
            tests++; if (!seen || cnt != 17) begin fails++; $display("FAIL timeout_cycles: begin=%b cycles=%0d required 1 17", seen, cnt); end
            tests++; if (out_err !== 1'b1 || out_gcd !== 16'd0) begin fails++; $display("FAIL timeout_result: err=%b g=%0d required 1 0", out_err, out_gcd); end
            step();
            tests++; if (out_err !== 1'b0) begin fails++; $display("FAIL timeout_err_clear: got %b required 0", out_err); end
            core_flush = 1'b1; step(); core_flush = 1'b0; core_stall = 1'b0;
            r = got_q[base];
            tests++; if (r.err !== 1'b1 || r.a !== a) begin fails++; $display("FAIL timeout_record: err=%b a=%0d required 1 %0d", r.err, r.a, a); end
            base = base + 1;
            rand_pair(a, b);
            push_one(a, b, ok);
        end
`else
        repeat (40) step();
        tests++; if (out_valid !== 1'b0 || out_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wait_forever: valid=%b err=%b busy=%b required 0 0 1", out_valid, out_err, busy); end
        core_stall = 1'b0;
`endif
        wait_got(base + 1, ok);
        r = got_q[base];
        tests++;
        if (!ok || r.a !== a || r.b !== b || r.g !== ref_gcd(a, b) || r.err !== 1'b0) begin
            fails++; $display("FAIL timeout_next_job: got %0d,%0d,%0d,%b required %0d,%0d,%0d,0", r.a, r.b, r.g, r.err, a, b, ref_gcd(a, b));
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a, b;
        logic ok;
        int base;
        res_t r;
        core_lat = 2; core_hold = 1; out_ready = 1'b1; core_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pair(a, b);
            push_one(a, b, ok);
        end
        repeat (6) step();
        base = got_q.size();
        tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rmid_pre: busy=%b valid=%b required 1 0", busy, out_valid); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({core_begin, core_a, core_b, out_valid, out_a, out_b, out_gcd, out_err, busy} !== 87'd0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rmid_async: got %h ready=%b required 0 1",
                {core_begin, core_a, core_b, out_valid, out_a, out_b, out_gcd, out_err, busy}, in_ready);
        end
        step();
        core_flush = 1'b1; step(); core_flush = 1'b0; core_stall = 1'b0;
        rst_n = 1'b1;
        repeat (20) step();
        tests++; if (got_q.size() != base || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_stale: results=%0d valid=%b busy=%b required %0d 0 0", got_q.size(), out_valid, busy, base); end
        rand_pair(a, b);
        push_one(a, b, ok);
        wait_got(base + 1, ok);
        r = got_q[base];
        tests++;
        if (!ok || r.a !== a || r.b !== b || r.g !== ref_gcd(a, b)) begin
            fails++; $display("FAIL rmid_fresh: got %0d,%0d,%0d required %0d,%0d,%0d", r.a, r.b, r.g, a, b, ref_gcd(a, b));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ea[$], eb[$];
        logic acc;
        int base, sent;
        res_t r;
        base = got_q.size(); sent = 0; in_valid = 1'b0; core_hold = 1; core_stall = 1'b0;
        for (int c = 0; c < 6000 && (sent < 24 || got_q.size() < base + 24); c++) begin
            if (!in_valid && sent < 24 && $urandom_range(0, 3) != 0) begin
                rand_pair(in_a, in_b);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            core_lat = $urandom_range(1, 8);
            acc = in_valid && in_ready;
            if (acc) begin
                ea.push_back(in_a); eb.push_back(in_b); sent++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tests++; if (got_q.size() != base + 24) begin fails++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), base + 24); end
        for (int i = 0; i < 24 && i < ea.size(); i++) begin
            r = got_q[base + i];
            tests++;
            if (r.a !== ea[i] || r.b !== eb[i] || r.g !== ref_gcd(ea[i], eb[i]) || r.err !== 1'b0) begin
                fails++; $display("FAIL rand_result%0d: got %0d,%0d,%0d,%b required %0d,%0d,%0d,0",
                    i, r.a, r.b, r.g, r.err, ea[i], eb[i], ref_gcd(ea[i], eb[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold_stall();
        test_passthrough();
        test_timeout();
        test_reset_mid();
        test_random();
        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
